rs_mul_sched: RTL
=================

// Module: rs_mul_sched
// PURPOSE
//  Allocation and issue scheduler for the multiplier reservation station.
//  - Picks free RS entries for up to two dispatched multiplies per cycle.
//  - Selects the oldest ready entry for issue and drives the RS write/clear controls.
//  - Tracks in-flight ops through a MUL_LAT-stage multiplier.
//  - Handles branch-miss kill, branch-success spec clear and writeback backpressure.
// PARAMETERS
//  ENT_NUM      2  number of RS entries
//  ENT_SEL      1  log2(ENT_NUM)
//  MUL_LAT      4  multiplier pipeline depth (>=1)
//  RRF_SEL      6  rename-register tag width
//  SPECTAG_LEN  5  speculation tag width (one-hot)
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  prmiss       in   1            branch mispredict this cycle
//  prsuccess    in   1            branch resolved correct this cycle
//  prtag        in   SPECTAG_LEN  tag of resolved branch
//  specfixtag   in   SPECTAG_LEN  tags killed on prmiss
//  req1,req2    in   1            dispatch slot 1/2 holds a multiply
//  busyvec      in   ENT_NUM      RS entry occupied
//  ready        in   ENT_NUM      RS entry operands ready
//  iss_rrftag   in   RRF_SEL      rrftag of entry at issueaddr
//  iss_dstval   in   1            dstval of entry at issueaddr
//  iss_spectag  in   SPECTAG_LEN  spectag of entry at issueaddr
//  iss_specbit  in   1            specbit of entry at issueaddr
//  wb_ready     in   1            writeback port accepts result
//  stall_dp     out  1            dispatch must hold; no entries written
//  we1,we2      out  1            write RS entry for slot 1/2
//  waddr1,waddr2 out ENT_SEL      entry for slot 1/2
//  clearbusy    out  1            issue this cycle; clear busy at issueaddr
//  issueaddr    out  ENT_SEL      issuing entry
//  mul_busy     out  1            any pipeline stage valid
//  wb_valid     out  1            final stage valid
//  wb_rrftag    out  RRF_SEL      final-stage tag
//  wb_dstval    out  1            final-stage dstval
//  wb_spectag   out  SPECTAG_LEN  final-stage spectag
//  wb_specbit   out  1            final-stage specbit
// BEHAVIOUR
//  Reset
//  - Age matrix, all stage valid/specbit bits and all payload regs are 0.
//  - During reset, we1/we2/clearbusy/stall_dp/wb_valid are 0.
//  Allocation (combinational from registered busyvec)
//  - waddr1 = lowest free index; waddr2 = next-lowest free index after waddr1.
//  - need = req1+req2; stall_dp = prmiss | (free count < need).
//  - we1 = req1 & ~stall_dp.
//  - we2 = req2 & ~stall_dp; if only req2 is set it uses waddr1's slot (waddr2 = lowest free).
//  - Entries freed by clearbusy this cycle are not reusable until next cycle.
//  Age
//  - older[i][j] = 1 means i was allocated before j.
//  - On a write to entry k, set older[j][k] = 1 for every j busy or written by slot 1 in the same cycle; clear older[k][*].
//  Issue
//  - cand = ready & busyvec.
//  - Pick the entry in cand with no older entry in cand.
//  - clearbusy = |cand & ~prmiss & ~freeze; issueaddr = picked index (0 when none).
//  Pipeline
//  - freeze = wb_valid & ~wb_ready; while frozen, no stage advances and no issue occurs.
//  - Otherwise stage0 <= {clearbusy, iss_*} and stage n <= stage n-1.
//  - Latency: issue in cycle t -> wb_valid in cycle t+MUL_LAT.
//  - Held wb_* outputs are stable while frozen.
//  - mul_busy = OR of stage valids.
//  prmiss (priority over prsuccess)
//  - Every stage with (spectag & specfixtag) != 0 drops valid next cycle, including the last stage while frozen.
//  - No issue or allocation that cycle.
//  prsuccess
//  - Every stage with spectag == prtag clears specbit next cycle.
//  - The stage being loaded this cycle also clears if iss_spectag == prtag.
//  Other
//  - Simultaneous alloc and issue are both allowed.
//  - Reset mid-operation discards all in-flight ops immediately.
// TESTING
//  - Alloc: busyvec=00, req1=req2=1 -> we1=we2=1, waddr1=0, waddr2=1, stall_dp=0. busyvec=01, req1=req2=1 -> stall_dp=1, we1=we2=0.
//  - Age: alloc entry1, then entry0; both ready -> issueaddr=1 first, entry0 the following cycle.
//  - Latency: issue rrftag=6'h2A at cycle 10, wb_ready=1 -> wb_valid=1 with wb_rrftag=6'h2A at cycle 14 only.
//  - Backpressure: wb_valid=1, wb_ready=0 for 3 cycles -> clearbusy=0, wb_* stable; releasing wb_ready resumes issue.
//  - Kill: stages with spectag 00001 and 00100, prmiss with specfixtag=00100 -> only the 00001 op reaches wb; stall_dp=1 that cycle.
//  - Spec clear: in-flight op spectag=00010 specbit=1, prsuccess prtag=00010 -> wb_specbit=0; prmiss+prsuccess same cycle -> kill only.

Source files
------------

// File: rtl/rs_mul_sched.sv
// rs_mul_sched: multiplier RS allocation, oldest-ready issue and in-flight pipeline tracking
module rs_mul_sched #(
  parameter int ENT_NUM     = 2,
  parameter int ENT_SEL     = 1,
  parameter int MUL_LAT     = 4,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  input  logic                   req1,
  input  logic                   req2,
  input  logic [ENT_NUM-1:0]     busyvec,
  input  logic [ENT_NUM-1:0]     ready,
  input  logic [RRF_SEL-1:0]     iss_rrftag,
  input  logic                   iss_dstval,
  input  logic [SPECTAG_LEN-1:0] iss_spectag,
  input  logic                   iss_specbit,
  input  logic                   wb_ready,
  output logic                   stall_dp,
  output logic                   we1,
  output logic                   we2,
  output logic [ENT_SEL-1:0]     waddr1,
  output logic [ENT_SEL-1:0]     waddr2,
  output logic                   clearbusy,
  output logic [ENT_SEL-1:0]     issueaddr,
  output logic                   mul_busy,
  output logic                   wb_valid,
  output logic [RRF_SEL-1:0]     wb_rrftag,
  output logic                   wb_dstval,
  output logic [SPECTAG_LEN-1:0] wb_spectag,
  output logic                   wb_specbit
);
  typedef struct packed {
    logic                   v;
    logic [RRF_SEL-1:0]     rrftag;
    logic                   dstval;
    logic [SPECTAG_LEN-1:0] spectag;
    logic                   specbit;
  } stage_t;
  stage_t st [MUL_LAT];
  stage_t prv [MUL_LAT];
  stage_t nxt [MUL_LAT];
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older;
  logic [ENT_SEL:0] free_cnt, need;
  logic [ENT_SEL-1:0] free1, free2, pick;
  logic got1, got2, found, blocked, short_ent, freeze, any_v;
  logic [ENT_NUM-1:0] cand;
  // Lowest and next-lowest free entries, plus how many entries are free
  always_comb begin
    free_cnt = '0;
    free1 = '0;
    free2 = '0;
    got1 = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < ENT_NUM; i++)
      if (!busyvec[i]) begin
        free_cnt = free_cnt + (ENT_SEL+1)'(1);
        if (got1 && !got2) begin
          free2 = ENT_SEL'(i);
          got2 = 1'b1;
        end
        if (!got1) begin
          free1 = ENT_SEL'(i);
          got1 = 1'b1;
        end
      end
  end
  assign need      = (ENT_SEL+1)'(req1) + (ENT_SEL+1)'(req2);
  assign short_ent = free_cnt < need;
  assign stall_dp  = ~reset & (prmiss | short_ent);
  assign we1       = ~reset & req1 & ~prmiss & ~short_ent;
  assign we2       = ~reset & req2 & ~prmiss & ~short_ent;
  assign waddr1    = free1;
  assign waddr2    = req1 ? free2 : free1;
  assign cand      = ready & busyvec;
  // Oldest candidate: the one no other candidate is marked older than
  always_comb begin
    pick = '0;
    found = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ENT_NUM; j++) blocked = blocked | (cand[j] & older[j][i]);
      if (cand[i] && !blocked && !found) begin
        pick = ENT_SEL'(i);
        found = 1'b1;
      end
    end
  end
  assign freeze    = wb_valid & ~wb_ready;
  assign clearbusy = ~reset & found & ~prmiss & ~freeze;
  assign issueaddr = pick;
  // Age matrix: a newly written entry is younger than everything busy and than slot 1's write
  always_ff @(posedge clk)
    if (reset) older <= '0;
    else begin
      if (we1) begin
        older[waddr1] <= '0;
        for (int j = 0; j < ENT_NUM; j++) if (busyvec[j]) older[j][waddr1] <= 1'b1;
      end
      if (we2) begin
        older[waddr2] <= '0;
        for (int j = 0; j < ENT_NUM; j++)
          if (busyvec[j] || (we1 && ENT_SEL'(j) == waddr1)) older[j][waddr2] <= 1'b1;
      end
    end
  // Next pipeline contents: shift or hold, then branch kill (wins) or spec-bit clear
  always_comb begin
    prv[0] = {clearbusy, iss_rrftag, iss_dstval, iss_spectag, iss_specbit};
    for (int n = 1; n < MUL_LAT; n++) prv[n] = st[n-1];
    for (int n = 0; n < MUL_LAT; n++) begin
      nxt[n] = freeze ? st[n] : prv[n];
      nxt[n].v = nxt[n].v & ~(prmiss & |(nxt[n].spectag & specfixtag));
      nxt[n].specbit = nxt[n].specbit & ~(~prmiss & prsuccess & (nxt[n].spectag == prtag));
    end
  end
  // Pipeline stage registers
  always_ff @(posedge clk)
    if (reset) st <= '{default: '0};
    else st <= nxt;
  // Any stage holding a live op
  always_comb begin
    any_v = 1'b0;
    for (int n = 0; n < MUL_LAT; n++) any_v = any_v | st[n].v;
  end
  assign mul_busy   = ~reset & any_v;
  assign wb_valid   = ~reset & st[MUL_LAT-1].v;
  assign wb_rrftag  = st[MUL_LAT-1].rrftag;
  assign wb_dstval  = st[MUL_LAT-1].dstval;
  assign wb_spectag = st[MUL_LAT-1].spectag;
  assign wb_specbit = st[MUL_LAT-1].specbit;
endmodule
